// File: rtl/fetch_sequencer_if.sv
// Fetch-side handshake bundle.
//   imem_req_*  : one-at-a-time fetch request to instruction memory
//   imem_resp_* : read-data return, one pulse per accepted request
//   inst_*      : single-entry instruction buffer handed to decode
// master = the sequencer, slave = memory + decode side.
interface fetch_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer.
// Issues one instruction-memory request at a time from the current PC,
// captures the returned word into a single-entry buffer for decode, and
// applies redirects (highest priority) and stalls (mask new requests only).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hold off new fetch requests
//   redirect_valid/addr : change fetch stream (addr[1:0] ignored)
//   fif (master)        : imem request/response + decode buffer handshake
//   redirect_count      : saturating count of redirect cycles
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_addr,
  fetch_sequencer_if.master    fif,
  output logic [CNT_W-1:0]     redirect_count
);

  typedef enum logic [1:0] {REQ, WAIT, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req_valid;
  logic [31:0] target;

  assign target = {redirect_addr[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    req_valid    = 1'b0;

    case (state_q)
      REQ: begin
        req_valid = !stall;
        if (req_valid && fif.imem_req_ready) begin
          state_d = WAIT;
          // Old-address request went out while redirecting: its data is stale.
          drop_d  = redirect_valid;
        end
        if (redirect_valid) pc_d = target;
      end

      WAIT: begin
        if (fif.imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_data_d  = fif.imem_resp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
            state_d      = FULL;
          end
        end else if (redirect_valid) begin
          // Response still in flight; mark it for discard when it lands.
          drop_d = 1'b1;
        end
        if (redirect_valid) pc_d = target;
      end

      FULL: begin
        // Redirect flushes the buffer even if decode takes it this cycle.
        if (redirect_valid) begin
          inst_valid_d = 1'b0;
          pc_d         = target;
          state_d      = REQ;
        end else if (fif.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
      end

      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      redirect_count <= '0;
    else if (redirect_valid && (redirect_count != {CNT_W{1'b1}}))
      redirect_count <= redirect_count + 1'b1;
  end

  assign fif.imem_req_valid = req_valid;
  assign fif.imem_req_addr  = pc_q;
  assign fif.inst_valid     = inst_valid_q;
  assign fif.inst_data      = inst_data_q;
  assign fif.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  fetch_sequencer_if f1();
  fetch_sequencer_if f2();

  fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fif(f1), .redirect_count(cnt1)
  );

  // Narrow-counter copy sees identical inputs; only its counter is checked.
  fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fif(f2), .redirect_count(cnt2)
  );

  assign f2.imem_req_ready  = f1.imem_req_ready;
  assign f2.imem_resp_valid = f1.imem_resp_valid;
  assign f2.imem_resp_data  = f1.imem_resp_data;
  assign f2.inst_ready      = f1.inst_ready;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // Reference model state: memory with one pending read, the PC of the next
  // instruction decode must see, and the number of redirect cycles.
  bit          rand_on = 0;
  int          lat_fix = 0;
  bit          mem_pend = 0;
  int          mem_lat  = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] exp_pc   = RESET_PC;
  int          nredir   = 0;
  bit          hold_req = 0, hold_inst = 0;
  logic [31:0] h_addr, h_data, h_pc;

  always @(negedge clk) begin
    chk("cnt16", 32'(cnt1), 32'((nredir > 65535) ? 65535 : nredir));
    chk("cnt2_sat", 32'(cnt2), 32'((nredir > 3) ? 3 : nredir));
    if (stall) chk("stall_mask", 32'(f1.imem_req_valid), 32'd0);
    if (hold_req && f1.imem_req_valid) chk("addr_hold", f1.imem_req_addr, h_addr);
    if (hold_inst) begin
      chk("inst_hold_v", 32'(f1.inst_valid), 32'd1);
      chk("inst_hold_d", f1.inst_data, h_data);
      chk("inst_hold_pc", f1.inst_pc, h_pc);
    end
    if (reset) begin
      exp_pc = RESET_PC; nredir = 0; mem_pend = 0;
    end else begin
      if (f1.imem_resp_valid) mem_pend = 0;
      if (f1.imem_req_valid && f1.imem_req_ready) begin
        chk("one_outstanding", 32'(mem_pend), 32'd0);
        mem_pend = 1;
        mem_addr = f1.imem_req_addr;
        mem_lat  = rand_on ? int'($urandom_range(0, 3)) : lat_fix;
      end
      if (f1.inst_valid && f1.inst_ready) begin
        chk("deliv_pc", f1.inst_pc, exp_pc);
        chk("deliv_data", f1.inst_data, word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc = redirect_addr & ~32'd3;
        nredir++;
      end
    end
    hold_req  = !reset && f1.imem_req_valid && !f1.imem_req_ready && !redirect_valid;
    hold_inst = !reset && f1.inst_valid && !f1.inst_ready && !redirect_valid;
    h_addr = f1.imem_req_addr; h_data = f1.inst_data; h_pc = f1.inst_pc;
  end

  // Memory: answers the pending read after mem_lat extra cycles.
  always @(posedge clk) begin
    #1;
    f1.imem_resp_valid = 1'b0;
    if (mem_pend) begin
      if (mem_lat == 0) begin
        f1.imem_resp_valid = 1'b1;
        f1.imem_resp_data  = word(mem_addr);
      end else mem_lat--;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_on) begin
      stall             = ($urandom % 100) < 20;
      redirect_valid    = ($urandom % 100) < 8;
      redirect_addr     = $urandom;
      f1.imem_req_ready = ($urandom % 100) < 70;
      f1.inst_ready     = ($urandom % 100) < 60;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_req(output logic [31:0] a);
    bit got = 0;
    a = 32'h0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (f1.imem_req_valid && f1.imem_req_ready) begin got = 1; a = f1.imem_req_addr; end
    end
    if (!got) chk("req_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_resp();
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = f1.imem_resp_valid;
    end
    if (!got) chk("resp_timeout", 32'(got), 32'd1);
  endtask

  task automatic chk_req_now(input string tag, input logic [31:0] exp);
    chk({tag, "_v"}, 32'(f1.imem_req_valid && f1.imem_req_ready), 32'd1);
    chk(tag, f1.imem_req_addr, exp);
  endtask

  initial begin
    logic [31:0] a, d, p;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
    f1.imem_req_ready = 1'b1; f1.inst_ready = 1'b1;
    f1.imem_resp_valid = 1'b0; f1.imem_resp_data = 32'h0;

    @(posedge clk); @(negedge clk);
    chk("rst_inst_valid", 32'(f1.inst_valid), 32'd0);
    chk("rst_inst_pc", f1.inst_pc, 32'h0);
    chk("rst_inst_data", f1.inst_data, 32'h0);
    chk("rst_pc", f1.imem_req_addr, RESET_PC);
    cyc(); reset = 1'b0;

    // Back-to-back fetches with single-cycle memory.
    for (int i = 0; i < 2; i++) begin
      wait_req(a); chk("seq_addr", a, 32'(i * 4));
      wait_resp(); @(negedge clk);
      chk("lat_valid", 32'(f1.inst_valid), 32'd1);
      chk("lat_pc", f1.inst_pc, 32'(i * 4));
    end

    // Redirect while waiting: response for 0x8 must be dropped.
    lat_fix = 2;
    wait_req(a); chk("addr_8", a, 32'h8);
    cyc(); redirect_valid = 1'b1; redirect_addr = 32'h103;
    cyc(); redirect_valid = 1'b0; lat_fix = 0;
    wait_req(a); chk("redir_addr", a, 32'h100);
    wait_resp(); @(negedge clk);
    chk("redir_pc", f1.inst_pc, 32'h100);
    chk("redir_cnt", 32'(cnt1), 32'd1);

    // Redirect coincident with the response.
    wait_req(a); chk("addr_104", a, 32'h104);
    cyc(); redirect_valid = 1'b1; redirect_addr = 32'h200;
    @(negedge clk); chk("coincide_resp", 32'(f1.imem_resp_valid), 32'd1);
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("coincide_nov", 32'(f1.inst_valid), 32'd0);
    chk_req_now("coincide_addr", 32'h200);
    wait_resp(); @(negedge clk);
    chk("coincide_pc", f1.inst_pc, 32'h200);

    // Stall in REQ for 5 cycles.
    cyc(); stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_noreq", 32'(f1.imem_req_valid), 32'd0);
      chk("stall_pc", f1.imem_req_addr, 32'h204);
    end
    cyc(); stall = 1'b0;
    wait_req(a); chk("post_stall_addr", a, 32'h204);

    // Decode backpressure, then redirect in FULL.
    cyc(); f1.inst_ready = 1'b0;
    for (int i = 0; i < 30 && !f1.inst_valid; i++) @(negedge clk);
    d = f1.inst_data; p = f1.inst_pc;
    chk("full_pc", p, 32'h204);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(f1.inst_valid), 32'd1);
      chk("bp_data", f1.inst_data, d);
      chk("bp_pc", f1.inst_pc, p);
      chk("bp_noreq", 32'(f1.imem_req_valid), 32'd0);
    end
    cyc(); redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFF;
    cyc(); redirect_valid = 1'b0; f1.inst_ready = 1'b1;
    @(negedge clk);
    chk("flush_nov", 32'(f1.inst_valid), 32'd0);
    chk_req_now("wrap_addr", 32'hFFFF_FFFC);
    wait_resp(); @(negedge clk);
    chk("wrap_pc", f1.inst_pc, 32'hFFFF_FFFC);
    wait_req(a); chk("wrap_next", a, 32'h0);
    chk("cnt_3", 32'(cnt1), 32'd3);

    // Two more redirects: narrow counter must stick at 3.
    cyc(); redirect_valid = 1'b1; redirect_addr = 32'h40;
    cyc();
    cyc(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("cnt_5", 32'(cnt1), 32'd5);
    chk("cnt2_5", 32'(cnt2), 32'd3);

    // Randomized traffic with a reset in the middle.
    rand_on = 1;
    repeat (1500) @(posedge clk);
    cyc(); reset = 1'b1;
    cyc(); cyc(); reset = 1'b0;
    repeat (1500) @(posedge clk);
    rand_on = 0;
    cyc(); stall = 1'b0; redirect_valid = 1'b0;
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the IF-stage program counter and the instruction-memory handshake. It issues one fetch request at a time, captures the returned word into a single-entry output buffer for decode, and applies redirects (branch/jump/flush target from EX) and stalls (hazard unit). It sits between the IF-stage PC logic, the instruction memory port and the IF/ID pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
CNT_W, 16, width of the redirect statistics counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  1 = do not issue new fetch requests (hazard hold)
redirect_valid  input  1  1 = change fetch stream to redirect_addr this cycle
redirect_addr  input  32  new PC; bits [1:0] ignored, forced to 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request when valid&ready
imem_req_addr  output  32  fetch address (= current PC)
imem_resp_valid  input  1  read data valid (one pulse per accepted request, >=1 cycle later)
imem_resp_data  input  32  instruction word
inst_valid  output  1  instruction buffer holds a valid instruction
inst_ready  input  1  decode consumes when inst_valid&inst_ready
inst_data  output  32  buffered instruction
inst_pc  output  32  PC of buffered instruction
redirect_count  output  CNT_W  number of redirects applied, saturating

Behaviour:
- Single clock, synchronous active-high reset. Reset values: pc=RESET_PC, state=REQ, inst_valid=0, inst_data=0, inst_pc=0, redirect_count=0, drop=0. Outputs imem_req_valid/imem_req_addr are combinational from state/pc/stall.
- States: REQ (request to issue), WAIT (one request outstanding), FULL (buffer holds instruction).
- REQ: imem_req_valid = !stall; imem_req_addr = pc. valid&ready -> WAIT. Address held stable while valid and not accepted, except on redirect.
- WAIT: imem_req_valid=0. On imem_resp_valid: if drop=0, load inst_data=resp_data, inst_pc=pc, inst_valid=1 next cycle, pc<=pc+4, -> FULL; if drop=1, discard word, clear drop, -> REQ.
- FULL: inst_valid=1, no requests. On inst_ready: inst_valid<=0, -> REQ.
- Latency: request accepted at edge N, response in cycle M (M>N) -> inst_valid high in cycle M+1. Max one outstanding request, so throughput <= 1 instr / 3 cycles.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Redirect (highest priority, honoured regardless of stall):
  - REQ: pc<=redirect_addr&~3; stay REQ. If the old-address request is accepted the same cycle, go WAIT with drop=1, then REQ at new pc.
  - WAIT without resp: drop<=1, pc<=target, stay WAIT. WAIT with resp same cycle: word discarded, pc<=target, -> REQ.
  - FULL: inst_valid<=0 (buffer flushed even if inst_ready=1 that cycle; that handshake still counts as consumed), pc<=target, -> REQ.
  - redirect_count increments by 1 per cycle redirect_valid=1, saturates at all-ones.
- Stall: only masks imem_req_valid in REQ; outstanding response still captured; buffered instruction still handed to decode.
- imem_resp_valid outside WAIT is ignored.
- Reset mid-operation: state returns to REQ at RESET_PC, drop cleared, buffer emptied; the memory shares this reset, so no stale response is expected.

Test Plan:
- Reset, RESET_PC=0, imem ready always, 1-cycle response latency, inst_ready=1 -> requests to 0x0,0x4,0x8; inst_pc follows; inst_valid one cycle after each resp.
- In WAIT after request to 0x8, redirect_valid=1 with addr 0x103 -> response for 0x8 dropped, next request 0x100, inst_pc=0x100, redirect_count=1.
- Redirect and imem_resp_valid in same WAIT cycle, addr 0x200 -> no inst_valid for old word, next request 0x200.
- stall=1 for 5 cycles in REQ -> imem_req_valid=0 throughout, pc unchanged; after release request issued with same address.
- inst_ready=0 for 4 cycles with inst_valid=1 -> inst_data/inst_pc stable, no new request; redirect in FULL clears inst_valid next cycle.
- pc=0xFFFF_FFFC fetched -> next request 0x0; CNT_W=2 with 5 redirects -> redirect_count=3.
